// File: rtl/pdp8_io_ctl_pkg.sv
// Shared definitions for the PDP-8 IOT controller: CPU major-state codes,
// device-00 function codes and the interrupt-system state encoding.
package pdp8_io_ctl_pkg;

  localparam logic [3:0] F0 = 4'd0;
  localparam logic [3:0] F1 = 4'd1;
  localparam logic [3:0] F2 = 4'd2;
  localparam logic [3:0] F3 = 4'd3;

  localparam logic [2:0] FN_SKON = 3'd0;
  localparam logic [2:0] FN_ION  = 3'd1;
  localparam logic [2:0] FN_IOF  = 3'd2;
  localparam logic [2:0] FN_SRQ  = 3'd3;
  localparam logic [2:0] FN_CAF  = 3'd7;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_PEND  = 2'd1,
    S_ON    = 2'd2,
    S_GRANT = 2'd3
  } int_state_e;

  // Device-00 functions that shut the interrupt system off from any state.
  function automatic logic forces_off(input logic [2:0] fn);
    return (fn == FN_SKON) || (fn == FN_IOF) || (fn == FN_CAF);
  endfunction

endpackage

// File: rtl/pdp8_io_ctl_if.sv
// Bus between the CPU/device side and the IOT controller.
// master = CPU and device side, slave = the controller.
interface pdp8_io_ctl_if #(parameter int NDEV = 8);

  logic [3:0]      state;
  logic            iot;
  logic [11:0]     mb;
  logic [5:0]      io_select;
  logic [NDEV-1:0] dev_selected;
  logic [NDEV-1:0] dev_skip;
  logic [NDEV-1:0] dev_interrupt;
  logic            int_ack;

  logic            cpu_skip;
  logic            cpu_int_req;
  logic            int_on;
  logic            io_clear;
  logic            io_undef;

  modport master (
    output state, iot, mb, io_select, dev_selected, dev_skip, dev_interrupt, int_ack,
    input  cpu_skip, cpu_int_req, int_on, io_clear, io_undef
  );

  modport slave (
    input  state, iot, mb, io_select, dev_selected, dev_skip, dev_interrupt, int_ack,
    output cpu_skip, cpu_int_req, int_on, io_clear, io_undef
  );

endinterface

// File: rtl/pdp8_io_ctl_skipmux.sv
// Reduces the per-device skip/select/interrupt vectors to single flags.
module pdp8_io_skipmux #(
  parameter int NDEV = 8
) (
  input  logic [NDEV-1:0] dev_selected,
  input  logic [NDEV-1:0] dev_skip,
  input  logic [NDEV-1:0] dev_interrupt,
  output logic            dev_skip_any,
  output logic            none_selected,
  output logic            int_any
);

  // A device skip only counts when that device has claimed the code.
  assign dev_skip_any  = |(dev_skip & dev_selected);
  assign none_selected = ~|dev_selected;
  assign int_any       = |dev_interrupt;

endmodule

// File: rtl/pdp8_io_ctl.sv
// PDP-8 IOT controller: decodes device 00 (interrupt system and CAF),
// aggregates device skips into a registered CPU skip, runs the interrupt
// enable state machine and flags IOTs that no device claimed.
module pdp8_io_ctl
  import pdp8_io_ctl_pkg::*;
#(
  parameter int NDEV = 8
) (
  input logic          clk,
  input logic          reset,
  pdp8_io_ctl_if.slave bus
);

  int_state_e st_q;
  int_state_e st_d;

  logic       is_f1;
  logic       dev00;
  logic [2:0] fn;
  logic       dev_skip_any;
  logic       none_selected;
  logic       int_any;
  logic       int_on_w;
  logic       skip_src;
  logic       caf;
  logic       undef_hit;
  logic       cpu_skip_q;
  logic       io_clear_q;
  logic       io_undef_q;
  logic       mb_unused;

  pdp8_io_skipmux #(.NDEV(NDEV)) u_skipmux (
    .dev_selected  (bus.dev_selected),
    .dev_skip      (bus.dev_skip),
    .dev_interrupt (bus.dev_interrupt),
    .dev_skip_any  (dev_skip_any),
    .none_selected (none_selected),
    .int_any       (int_any)
  );

  assign is_f1     = (bus.state == F1);
  assign dev00     = is_f1 && bus.iot && (bus.io_select == 6'd0);
  assign fn        = bus.mb[2:0];
  assign mb_unused = ^bus.mb[11:3];
  assign int_on_w  = (st_q == S_ON) || (st_q == S_GRANT);
  assign caf       = dev00 && (fn == FN_CAF);
  assign undef_hit = is_f1 && bus.iot && (bus.io_select != 6'd0) && none_selected;

  // SKON tests the interrupt state before this instruction turns it off.
  assign skip_src = dev_skip_any
                  | (dev00 && (fn == FN_SKON) && int_on_w)
                  | (dev00 && (fn == FN_SRQ) && int_any);

  // Interrupt-system state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_q <= S_OFF;
    else       st_q <= st_d;
  end

  // Next state: SKON/IOF/CAF win over everything; ION arrives in F1 so it
  // can only be promoted by a later F3.
  always_comb begin
    st_d = st_q;
    if (dev00 && forces_off(fn)) begin
      st_d = S_OFF;
    end else begin
      unique case (st_q)
        S_OFF:   if (dev00 && (fn == FN_ION)) st_d = S_PEND;
        S_PEND:  if (bus.state == F3) st_d = S_ON;
        S_ON:    if ((bus.state == F3) && int_any) st_d = S_GRANT;
        S_GRANT: if (bus.int_ack) st_d = S_OFF;
        default: st_d = S_OFF;
      endcase
    end
  end

  // Skip is captured once per instruction, in F1, and held until the next F1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cpu_skip_q <= 1'b0;
    else if (is_f1) cpu_skip_q <= skip_src;
  end

  // CAF pulse and the sticky undefined-device flag, which CAF also clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_clear_q <= 1'b0;
      io_undef_q <= 1'b0;
    end else begin
      io_clear_q <= caf;
      if (caf)            io_undef_q <= 1'b0;
      else if (undef_hit) io_undef_q <= 1'b1;
    end
  end

  assign bus.cpu_skip    = cpu_skip_q;
  assign bus.cpu_int_req = (st_q == S_GRANT);
  assign bus.int_on      = int_on_w;
  assign bus.io_clear    = io_clear_q;
  assign bus.io_undef    = io_undef_q;

endmodule

// File: doc/pdp8_io_ctl.md
PDP8_IO_CTL -- requirements
Module: pdp8_io_ctl

Interface
REQ-001 Parameter NDEV, default 8: number of IOT device ports aggregated (1..16).
REQ-002 Port clk, input, 1: system clock; all state is updated on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port state, input, 4: CPU major state; F0=0, F1=1, F2=2, F3=3.
REQ-005 Port iot, input, 1: current instruction is an IOT.
REQ-006 Port mb, input, 12: memory buffer; mb[2:0] is the IOT function code.
REQ-007 Port io_select, input, 6: IOT device code.
REQ-008 Port dev_selected, input, NDEV: per-device "device code claimed" flags.
REQ-009 Port dev_skip, input, NDEV: per-device skip requests.
REQ-010 Port dev_interrupt, input, NDEV: per-device level interrupt requests.
REQ-011 Port int_ack, input, 1: CPU entering the interrupt cycle, one-clock pulse.
REQ-012 Port cpu_skip, output, 1: registered skip to the CPU.
REQ-013 Port cpu_int_req, output, 1: registered interrupt request to the CPU.
REQ-014 Port int_on, output, 1: interrupt system enabled (ION state).
REQ-015 Port io_clear, output, 1: one-clock pulse that clears all devices (CAF).
REQ-016 Port io_undef, output, 1: sticky flag; an IOT addressed no device.

Function
REQ-017 Device code 00 SHALL be decoded internally, and only in F1 with iot=1.
REQ-018 SKON (mb[2:0]=0) SHALL skip if int_on=1 and then turn the interrupt system off.
REQ-019 ION (mb[2:0]=1) SHALL enter PEND; int_on SHALL rise at the next F3 clock, so it takes effect one instruction late.
REQ-020 IOF (mb[2:0]=2) SHALL enter OFF immediately, and SHALL also cancel a pending ION.
REQ-021 SRQ (mb[2:0]=3) SHALL skip if |dev_interrupt is 1.
REQ-022 CAF (mb[2:0]=7) SHALL enter OFF, pulse io_clear for exactly one clock, and clear io_undef.
REQ-023 Other device-00 function codes SHALL be no-ops.
REQ-024 The skip source SHALL be |(dev_skip & dev_selected) OR the internal device-00 skip.
REQ-025 cpu_skip SHALL be latched on the clock in which state=F1 and held until the next F1 clock; otherwise it holds its value.
REQ-026 The state machine SHALL have states OFF, PEND, ON and GRANT.
REQ-027 Transitions: OFF->PEND on ION; PEND->ON at F3; ON->GRANT at F3 when |dev_interrupt=1; GRANT->OFF on int_ack.
REQ-028 IOF, SKON and CAF SHALL force OFF from any state.
REQ-029 int_on SHALL be 1 in ON and in GRANT.
REQ-030 cpu_int_req SHALL be 1 only in GRANT, and SHALL drop in the clock after int_ack.
REQ-031 If dev_interrupt falls while in GRANT, the state SHALL remain GRANT and cpu_int_req SHALL remain 1; the request is not withdrawn.
REQ-032 If an ION and an F3 occur in the same clock, the ION SHALL still take effect at the following F3, not the current one.
REQ-033 int_ack received outside GRANT SHALL be ignored.
REQ-034 io_undef SHALL set when, in F1 with iot=1, io_select is nonzero and dev_selected is all zeros.

Reset
REQ-035 On reset the state SHALL be OFF, and cpu_skip, cpu_int_req, int_on, io_clear and io_undef SHALL all be 0, asynchronously.
REQ-036 A reset asserted while in GRANT or PEND SHALL abandon the request, leaving no residual pulse.

Structure
REQ-037 The state encoding, the F0..F3 constants and the device-00 function codes SHALL live in the shared pdp8 package.
REQ-038 One sub-module, pdp8_io_skipmux, SHALL perform the parameterised NDEV skip and select reduction.

Verification
REQ-039 Run ION, then NOP, with dev_interrupt[2]=1; the bench SHALL check that cpu_int_req=0 after the ION F3, and =1 after the NOP F3.
REQ-040 From GRANT, pulse int_ack; the bench SHALL check cpu_int_req=0 and int_on=0 on the next clock.
REQ-041 Execute IOT 6133 (io_select=13, mb=0o6133) with dev_selected[1]=1 and dev_skip[1]=1; the bench SHALL check cpu_skip=1 from F2 until the next F1.
REQ-042 Execute SKON with int_on=1; the bench SHALL check cpu_skip=1 and int_on=0; repeated with int_on=0, cpu_skip=0.
REQ-043 Execute CAF in state ON; the bench SHALL check that io_clear is high for exactly 1 clock, the state is OFF and io_undef=0.
REQ-044 Execute IOT 6571 with no device selected; the bench SHALL check io_undef=1, that it stays 1 through later IOTs, and that reset clears it asynchronously.
